// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: FSM state and op encodings plus line
// width helpers, shared by the data cache and the line responder.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    GRANT = 2'd2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_LINE_BITS     = 32 << DEF_LINE_ADDR_LEN;

  // Width in bits of a line holding 2^line_addr_len 32-bit words.
  function automatic int line_bits(input int line_addr_len);
    return 32 << line_addr_len;
  endfunction

endpackage

// File: rtl/mem_line_store.sv
// Line-wide single-port storage with registered read. Contents are not reset,
// so the array maps onto block RAM.
module mem_line_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_reg;

  // Write the line on we; capture the addressed line into the read register on re.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory line responder: accepts whole-line reads/writes, waits a fixed
// latency, then commits or returns the line and pulses mem_gnt for one cycle.
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 8,
  parameter int LATENCY       = 50
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               mem_rd_req,
  input  logic                               mem_wr_req,
  input  logic [32-LINE_ADDR_LEN-2-1:0]      mem_addr,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]     mem_wr_line,
  output logic [(32<<LINE_ADDR_LEN)-1:0]     mem_rd_line,
  output logic                               mem_gnt,
  output logic                               busy,
  output logic [31:0]                        rd_count,
  output logic [31:0]                        wr_count
);

  localparam int              LINE_W = line_bits(LINE_ADDR_LEN);
  localparam logic [7:0]      LOAD   = 8'(LATENCY - 1);

  state_t                    state_reg, state_next;
  op_t                       op_reg;
  logic [MEM_ADDR_LEN-1:0]   addr_reg;
  logic [LINE_W-1:0]         wline_reg;
  logic [7:0]                cnt_reg;
  logic [31:0]               rd_count_reg, wr_count_reg;
  logic                      rd_valid_reg;
  logic                      accept, access, store_we, store_re;
  logic [LINE_W-1:0]         store_rdata;

  // Only the low MEM_ADDR_LEN address bits select a line; upper bits alias.
  logic unused_addr;
  assign unused_addr = ^mem_addr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and control: write wins in IDLE, a dropped request aborts BUSY.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_wr_req || mem_rd_req) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if ((op_reg == WRITE) ? !mem_wr_req : !mem_rd_req) begin
          state_next = IDLE;
        end else if (cnt_reg == 8'd0) begin
          access     = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign store_we = access && (op_reg == WRITE);
  assign store_re = access && (op_reg == READ);
  assign mem_gnt  = (state_reg == GRANT);
  assign busy     = (state_reg != IDLE);

  // Latch the request on acceptance and run the latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= READ;
      addr_reg  <= '0;
      wline_reg <= '0;
      cnt_reg   <= 8'd0;
    end else if (accept) begin
      op_reg   <= mem_wr_req ? WRITE : READ;
      addr_reg <= mem_addr[MEM_ADDR_LEN-1:0];
      if (mem_wr_req) wline_reg <= mem_wr_line;
      cnt_reg  <= LOAD;
    end else if (state_reg == BUSY && cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  // Transaction counters bump in the grant cycle; rd_valid gates the read line
  // to zero until the first read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_reg <= 32'd0;
      wr_count_reg <= 32'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (store_re) rd_valid_reg <= 1'b1;
      if (state_reg == GRANT) begin
        if (op_reg == WRITE) wr_count_reg <= wr_count_reg + 32'd1;
        else                 rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  mem_line_store #(
    .ADDR_W (MEM_ADDR_LEN),
    .DATA_W (LINE_W)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .re    (store_re),
    .addr  (addr_reg),
    .wdata (wline_reg),
    .rdata (store_rdata)
  );

  assign mem_rd_line = rd_valid_reg ? store_rdata : '0;
  assign rd_count    = rd_count_reg;
  assign wr_count    = wr_count_reg;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: drivers push expected grants,
// a negedge monitor pops and compares whenever mem_gnt is seen.
module tb_mem_line_responder;

  localparam int LAT = 4;
  localparam int LW  = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_rd_req = 1'b0;
  logic            mem_wr_req = 1'b0;
  logic [26:0]     mem_addr = '0;
  logic [LW-1:0]   mem_wr_line = '0;
  logic [LW-1:0]   mem_rd_line;
  logic            mem_gnt;
  logic            busy;
  logic [31:0]     rd_count;
  logic [31:0]     wr_count;

  mem_line_responder #(
    .LINE_ADDR_LEN (3),
    .MEM_ADDR_LEN  (8),
    .LATENCY       (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rd_req  (mem_rd_req),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wr_line (mem_wr_line),
    .mem_rd_line (mem_rd_line),
    .mem_gnt     (mem_gnt),
    .busy        (busy),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_wr;
    logic [LW-1:0] line;    // expected mem_rd_line in the grant cycle
    int unsigned   gnt_cyc;
    int unsigned   rd_cnt;  // expected counters after the grant
    int unsigned   wr_cnt;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int unsigned   exp_rd = 0;
  int unsigned   exp_wr = 0;
  logic [LW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Monitor: every grant must match the head of the scoreboard.
  bit          cnt_pend = 0;
  int unsigned pend_rd, pend_wr;
  always @(negedge clk) begin
    if (cnt_pend) begin
      check("rd_count_after_gnt", LW'(rd_count), LW'(pend_rd));
      check("wr_count_after_gnt", LW'(wr_count), LW'(pend_wr));
      cnt_pend = 0;
    end
    if (mem_gnt) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", LW'(1), LW'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.is_wr ? "wr_gnt_cycle" : "rd_gnt_cycle", LW'(cyc), LW'(e.gnt_cyc));
        check(e.is_wr ? "rd_line_held_on_wr" : "rd_line", mem_rd_line, e.line);
        $display("txn %s gnt at cycle %0d line %h", e.is_wr ? "WR" : "RD", cyc, mem_rd_line[31:0]);
        pend_rd  = e.rd_cnt;
        pend_wr  = e.wr_cnt;
        cnt_pend = 1;
      end
    end
  end

  task automatic push_exp(input bit is_wr, input logic [LW-1:0] line, input int unsigned gc);
    exp_t e;
    if (is_wr) exp_wr++; else exp_rd++;
    e.is_wr = is_wr; e.line = line; e.gnt_cyc = gc; e.rd_cnt = exp_rd; e.wr_cnt = exp_wr;
    sb.push_back(e);
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_gnt) return;
    end
    check("gnt_timeout", LW'(0), LW'(1));
  endtask

  task automatic write_line(input logic [26:0] a, input logic [LW-1:0] l);
    push_exp(1'b1, last_rd, cyc + LAT + 1);
    mem_addr = a; mem_wr_line = l; mem_wr_req = 1'b1;
    wait_gnt();
    mem_wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_line(input logic [26:0] a, input logic [LW-1:0] l);
    last_rd = l;
    push_exp(1'b0, l, cyc + LAT + 1);
    mem_addr = a; mem_rd_req = 1'b1;
    wait_gnt();
    mem_rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  LW'(mem_gnt),  LW'(0));
    check({tag, "_busy"}, LW'(busy),     LW'(0));
    check({tag, "_rdl"},  mem_rd_line,   LW'(0));
    check({tag, "_rdc"},  LW'(rd_count), LW'(0));
    check({tag, "_wrc"},  LW'(wr_count), LW'(0));
  endtask

  logic [LW-1:0] line_a, line_b;
  int unsigned   c0;

  initial begin
    // 1. Reset then idle
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_reset_outputs("idle");
    end

    // 2. Write then read line 0x05
    line_a = make_line(32'h1111_1100);
    write_line(27'h05, line_a);
    read_line(27'h05, line_a);

    // 3. Simultaneous requests on line 0x0A: write first, read LAT+2 later
    line_b = make_line(32'hA0A0_0A00);
    c0 = cyc;
    push_exp(1'b1, last_rd, c0 + LAT + 1);
    last_rd = line_b;
    push_exp(1'b0, line_b, c0 + 2*LAT + 3);
    mem_addr = 27'h0A; mem_wr_line = line_b;
    mem_wr_req = 1'b1; mem_rd_req = 1'b1;
    wait_gnt();
    mem_wr_req = 1'b0;
    wait_gnt();
    mem_rd_req = 1'b0;
    @(negedge clk);

    // 4. Abort: read dropped after 2 BUSY cycles, then a normal read
    mem_addr = 27'h05; mem_rd_req = 1'b1;
    @(negedge clk);
    check("abort_busy1", LW'(busy), LW'(1));
    @(negedge clk);
    mem_rd_req = 1'b0;
    @(negedge clk);
    check("abort_idle", LW'(busy), LW'(0));
    repeat (10) @(negedge clk);
    check("abort_rdc", LW'(rd_count), LW'(exp_rd));
    check("abort_rdl_held", mem_rd_line, last_rd);
    read_line(27'h05, line_a);

    // 5. Address alias: 0x103 and 0x003 are the same line
    line_a = make_line(32'h0103_0000);
    write_line(27'h103, line_a);
    read_line(27'h003, line_a);

    // 6. Mid-transaction reset drops an in-flight write to 0x20
    line_a = make_line(32'h2020_2000);
    line_b = make_line(32'hDEAD_BE00);
    write_line(27'h20, line_a);
    mem_addr = 27'h20; mem_wr_line = line_b; mem_wr_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; mem_wr_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0; last_rd = '0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    read_line(27'h20, line_a);

    // Drain: scoreboard must be empty
    repeat (5) @(negedge clk);
    check("sb_empty", LW'(sb.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
